ysyx_22051086_lsu_stage: RTL and testbench



---
 rtl/ysyx_22051086_lsu_stage.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22051086_lsu_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051086_lsu_stage.sv
// Memory-access stage between EX and WB: one instruction in flight, single-outstanding data-memory transaction.
// Latency: non-memory op 1 cycle; memory op 3 cycles minimum (REQ, WAIT, DONE), longer with gnt/rvalid delay.
// Backpressure: ls_allowin drops while a memory op is unresolved or WB stalls; result and data_* outputs held.
module ysyx_22051086_lsu_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         es_to_ls_valid,
    input  logic [202:0] es_to_ls_bus,
    output logic         ls_allowin,
    output logic         ls_to_wb_valid,
    input  logic         wb_allowin,
    output logic [133:0] ls_to_wb_bus,
    output logic [69:0]  ls_fwd_bus,
    output logic         ls_load_pending,
    output logic         data_req,
    output logic         data_we,
    output logic [63:0]  data_addr,
    output logic [63:0]  data_wdata,
    output logic [7:0]   data_wstrb,
    input  logic         data_gnt,
    input  logic         data_rvalid,
    input  logic [63:0]  data_rdata
);

    typedef struct packed {
        logic [63:0] pc;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic [63:0] alu_result;
        logic [63:0] st_data;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        ld_unsigned;
    } es_bus_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic [63:0] reg_wdata;
    } wb_bus_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    es_bus_t     es_in;
    es_bus_t     bus_q, bus_d;
    state_e      state_q, state_d;
    logic        ls_valid_q, ls_valid_d;
    logic [63:0] ld_result_q, ld_result_d;

    logic        mem_op;
    logic        ls_ready_go;
    logic        accept;
    logic        leave;
    logic [5:0]  byte_shamt;
    logic [63:0] ld_shifted;
    logic [63:0] ld_ext;
    logic [7:0]  strb_base;
    wb_bus_t     wb_bus;

    assign es_in       = es_to_ls_bus;
    assign mem_op      = bus_q.mem_rd | bus_q.mem_wr;
    assign ls_ready_go = !mem_op || (state_q == S_DONE);
    assign ls_allowin  = !ls_valid_q || (ls_ready_go && wb_allowin);
    assign ls_to_wb_valid = ls_valid_q && ls_ready_go;
    assign accept      = es_to_ls_valid && ls_allowin;
    assign leave       = ls_to_wb_valid && wb_allowin;
    assign byte_shamt  = {bus_q.alu_result[2:0], 3'b000};

    // Byte lane of the access inside the aligned doubleword selects both the
    // load slice and the store lane placement.
    always_comb begin
        ld_shifted = data_rdata >> byte_shamt;
        ld_ext     = ld_shifted;
        case (bus_q.mem_size)
            2'd0: ld_ext = {{56{!bus_q.ld_unsigned && ld_shifted[7]}},  ld_shifted[7:0]};
            2'd1: ld_ext = {{48{!bus_q.ld_unsigned && ld_shifted[15]}}, ld_shifted[15:0]};
            2'd2: ld_ext = {{32{!bus_q.ld_unsigned && ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    always_comb begin
        strb_base = 8'hFF;
        case (bus_q.mem_size)
            2'd0: strb_base = 8'h01;
            2'd1: strb_base = 8'h03;
            2'd2: strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    assign data_req   = (state_q == S_REQ);
    assign data_we    = bus_q.mem_wr;
    assign data_addr  = {bus_q.alu_result[63:3], 3'b000};
    assign data_wdata = bus_q.st_data << byte_shamt;
    assign data_wstrb = strb_base << bus_q.alu_result[2:0];

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        ls_valid_d  = ls_valid_q;
        ld_result_d = ld_result_q;

        // gnt/rvalid only matter in the state that is waiting for them.
        case (state_q)
            S_REQ: begin
                if (data_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rvalid) begin
                    state_d     = S_DONE;
                    ld_result_d = ld_ext;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (accept) begin
            bus_d      = es_in;
            ls_valid_d = 1'b1;
            state_d    = (es_in.mem_rd || es_in.mem_wr) ? S_REQ : S_IDLE;
        end else if (leave) begin
            ls_valid_d = 1'b0;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bus_q       <= '0;
            ls_valid_q  <= 1'b0;
            ld_result_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            ls_valid_q  <= ls_valid_d;
            ld_result_q <= ld_result_d;
        end
    end

    always_comb begin
        wb_bus.pc        = bus_q.pc;
        wb_bus.reg_wen   = bus_q.reg_wen;
        wb_bus.reg_waddr = bus_q.reg_waddr;
        wb_bus.reg_wdata = bus_q.mem_rd ? ld_result_q : bus_q.alu_result;
    end

    assign ls_to_wb_bus    = wb_bus;
    assign ls_fwd_bus      = {ls_valid_q && bus_q.reg_wen, bus_q.reg_waddr, wb_bus.reg_wdata};
    assign ls_load_pending = ls_valid_q && bus_q.mem_rd && (state_q != S_DONE);

endmodule

// File: tb/tb_ysyx_22051086_lsu_stage.sv
// Directed bench for the LSU stage: stimulus pushes expected WB buses, a monitor pops on each WB handoff.
module tb_ysyx_22051086_lsu_stage;

    logic         clk;
    logic         rst;
    logic         es_to_ls_valid;
    logic [202:0] es_to_ls_bus;
    logic         ls_allowin;
    logic         ls_to_wb_valid;
    logic         wb_allowin;
    logic [133:0] ls_to_wb_bus;
    logic [69:0]  ls_fwd_bus;
    logic         ls_load_pending;
    logic         data_req;
    logic         data_we;
    logic [63:0]  data_addr;
    logic [63:0]  data_wdata;
    logic [7:0]   data_wstrb;
    logic         data_gnt;
    logic         data_rvalid;
    logic [63:0]  data_rdata;

    int total = 0;
    int bad   = 0;
    logic [133:0] exp_q[$];

    ysyx_22051086_lsu_stage dut (
        .clk             (clk),
        .rst             (rst),
        .es_to_ls_valid  (es_to_ls_valid),
        .es_to_ls_bus    (es_to_ls_bus),
        .ls_allowin      (ls_allowin),
        .ls_to_wb_valid  (ls_to_wb_valid),
        .wb_allowin      (wb_allowin),
        .ls_to_wb_bus    (ls_to_wb_bus),
        .ls_fwd_bus      (ls_fwd_bus),
        .ls_load_pending (ls_load_pending),
        .data_req        (data_req),
        .data_we         (data_we),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_wstrb      (data_wstrb),
        .data_gnt        (data_gnt),
        .data_rvalid     (data_rvalid),
        .data_rdata      (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [202:0] mk(input logic [63:0] pc, input logic wen, input logic [4:0] wa,
                                        input logic [63:0] alu, input logic [63:0] st, input logic rd,
                                        input logic wr, input logic [1:0] sz, input logic uns);
        return {pc, wen, wa, alu, st, rd, wr, sz, uns};
    endfunction

    function automatic logic [133:0] wb(input logic [63:0] pc, input logic wen, input logic [4:0] wa,
                                        input logic [63:0] wd);
        return {pc, wen, wa, wd};
    endfunction

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every WB handoff must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && ls_to_wb_valid && wb_allowin) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_handoff actual=%h required=none", ls_to_wb_bus);
                end else begin
                    chk("wb_bus", ls_to_wb_bus, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [202:0] b);
        bit ok;
        ok = 1'b0;
        es_to_ls_valid = 1'b1;
        es_to_ls_bus   = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ls_allowin) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        es_to_ls_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL issue_timeout actual=0 required=1");
        end
    endtask

    // Entered #1 after the accept edge; leaves #1 after the rvalid edge.
    task automatic run_mem(input int gdly, input logic [63:0] rd);
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            chk("req_hold", data_req, 1);
            @(posedge clk);
            #1;
        end
        data_gnt = 1'b1;
        @(negedge clk);
        chk("req_at_gnt", data_req, 1);
        chk("no_valid_req", ls_to_wb_valid, 0);
        @(posedge clk);
        #1;
        data_gnt    = 1'b0;
        data_rvalid = 1'b1;
        data_rdata  = rd;
        @(negedge clk);
        chk("req_drop_wait", data_req, 0);
        chk("no_valid_wait", ls_to_wb_valid, 0);
        @(posedge clk);
        #1;
        data_rvalid = 1'b0;
    endtask

    task automatic finish_one();
        @(negedge clk);
        chk("valid_done", ls_to_wb_valid, 1);
        chk("pending_done", ls_load_pending, 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  wa;
        logic [63:0] alu;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] rd;
        logic [63:0] res;
    } ld_vec_t;

    initial begin
        ld_vec_t lv[5];
        logic [133:0] ld_exp;

        rst = 1'b0;
        es_to_ls_valid = 1'b0;
        es_to_ls_bus = '0;
        wb_allowin = 1'b1;
        data_gnt = 1'b0;
        data_rvalid = 1'b0;
        data_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ls_to_wb_valid, 0);
        chk("rst_req", data_req, 0);
        chk("rst_pending", ls_load_pending, 0);
        chk("rst_fwd_vld", ls_fwd_bus[69], 0);
        chk("rst_allowin", ls_allowin, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU op: one-cycle stage.
        exp_q.push_back(wb(64'h8000_0000, 1'b1, 5'd5, 64'h1234));
        issue(mk(64'h8000_0000, 1'b1, 5'd5, 64'h1234, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0));
        @(negedge clk);
        chk("alu_valid", ls_to_wb_valid, 1);
        chk("alu_fwd", ls_fwd_bus, {1'b1, 5'd5, 64'h1234});
        @(posedge clk);
        #1;

        lv[0] = '{64'h8000_0004, 5'd10, 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        lv[1] = '{64'h8000_0008, 5'd11, 64'h8000_0007, 2'd0, 1'b0, 64'hFF00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        lv[2] = '{64'h8000_000C, 5'd12, 64'h8000_0007, 2'd0, 1'b1, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF};
        lv[3] = '{64'h8000_0014, 5'd13, 64'h8000_2000, 2'd2, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h0000_0000_8000_0001};
        lv[4] = '{64'h8000_0018, 5'd14, 64'h8000_2000, 2'd2, 1'b0, 64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_8000_0001};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(wb(lv[i].pc, 1'b1, lv[i].wa, lv[i].res));
            issue(mk(lv[i].pc, 1'b1, lv[i].wa, lv[i].alu, 64'h0, 1'b1, 1'b0, lv[i].sz, lv[i].uns));
            chk("ld_addr", data_addr, {lv[i].alu[63:3], 3'b000});
            chk("ld_we", data_we, 0);
            run_mem(0, lv[i].rd);
            finish_one();
        end

        // SH with a 4-cycle grant delay.
        exp_q.push_back(wb(64'h8000_0010, 1'b0, 5'd0, 64'h8000_1006));
        issue(mk(64'h8000_0010, 1'b0, 5'd0, 64'h8000_1006, 64'hABCD, 1'b0, 1'b1, 2'd1, 1'b0));
        chk("sh_wstrb", data_wstrb, 8'hC0);
        chk("sh_wdata", data_wdata, 64'hABCD_0000_0000_0000);
        chk("sh_we", data_we, 1);
        chk("sh_addr", data_addr, 64'h8000_1000);
        run_mem(4, 64'h0);
        finish_one();

        // LD stalled in DONE, SD queued behind it.
        wb_allowin = 1'b0;
        ld_exp = wb(64'h8000_001C, 1'b1, 5'd15, 64'h8877_6655_4433_2211);
        exp_q.push_back(ld_exp);
        exp_q.push_back(wb(64'h8000_0020, 1'b0, 5'd0, 64'h8000_3008));
        issue(mk(64'h8000_001C, 1'b1, 5'd15, 64'h8000_3000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0));
        run_mem(0, 64'h8877_6655_4433_2211);
        es_to_ls_valid = 1'b1;
        es_to_ls_bus = mk(64'h8000_0020, 1'b0, 5'd0, 64'h8000_3008, 64'h0123_4567_89AB_CDEF,
                          1'b0, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_allowin", ls_allowin, 0);
            chk("stall_valid", ls_to_wb_valid, 1);
            chk("stall_req", data_req, 0);
            chk("stall_bus", ls_to_wb_bus, ld_exp);
            @(posedge clk);
            #1;
        end
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("handoff_allowin", ls_allowin, 1);
        @(posedge clk);
        #1;
        es_to_ls_valid = 1'b0;
        chk("sd_wstrb", data_wstrb, 8'hFF);
        chk("sd_wdata", data_wdata, 64'h0123_4567_89AB_CDEF);
        chk("sd_addr", data_addr, 64'h8000_3008);
        run_mem(0, 64'h0);
        finish_one();

        // Reset while in WAIT, then a stray rvalid.
        issue(mk(64'h8000_0024, 1'b1, 5'd16, 64'h8000_4000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0));
        data_gnt = 1'b1;
        @(posedge clk);
        #1;
        data_gnt = 1'b0;
        @(negedge clk);
        chk("wait_pending", ls_load_pending, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_wait_req", data_req, 0);
        chk("rst_wait_fwd", ls_fwd_bus[69], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_rvalid = 1'b1;
        data_rdata = 64'h5555_5555_5555_5555;
        @(posedge clk);
        #1;
        data_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("late_rvalid_valid", ls_to_wb_valid, 0);
            chk("late_rvalid_req", data_req, 0);
            chk("late_rvalid_allowin", ls_allowin, 1);
        end

        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
